// File: rtl/led_trace_buffer.sv
// Logs every change of the core's 6-bit LED value into a FIFO and replays the values, each held HOLD_CYCLES cycles.
// Latency: a change written at edge k is popped and shown after edge k+1 when the display is idle.
// Backpressure: none upstream; a change that finds the FIFO full with no pop that cycle is dropped and sets sticky overflow.
//
// Ports:
//   clk      system clock, all state changes on the rising edge
//   nrst     asynchronous active-low reset
//   dataIn   core LED data output (6 bits)
//   ledOut   LED pin drive, inverted copy of the shown register when ACTIVE_LOW
//   overflow sticky flag, a change was dropped because the FIFO was full
//   pending  number of FIFO entries waiting to be shown
module led_trace_buffer #(
  parameter int DEPTH       = 8,
  parameter int HOLD_CYCLES = 13500000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic [5:0]                   dataIn,
  output logic [5:0]                   ledOut,
  output logic                         overflow,
  output logic [$clog2(DEPTH+1)-1:0]   pending
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  // A counter wide enough for 0..HOLD_CYCLES-1, never narrower than one bit.
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t          state, stateNext;
  logic [5:0]      lastSeen;
  logic [5:0]      shown;
  logic [5:0]      fifoMem [DEPTH];
  logic [PW-1:0]   rdPtr, wrPtr;
  logic [CW-1:0]   count;
  logic [HW-1:0]   holdCnt, holdNext;
  logic            push, pop, full, accept, drop;

  assign push   = (dataIn != lastSeen);
  assign full   = (count == FULL_CNT);
  // When full, a pop in the same cycle frees the head slot, which is exactly wrPtr.
  assign accept = push && (!full || pop);
  assign drop   = push && full && !pop;

  // Display FSM: next state, hold reload and pop request.
  always_comb begin
    stateNext = state;
    holdNext  = holdCnt;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          holdNext  = HOLD_LAST;
          stateNext = HOLD;
        end
      end
      HOLD: begin
        if (holdCnt != '0) begin
          holdNext = holdCnt - HW'(1);
        end else if (count != '0) begin
          pop      = 1'b1;
          holdNext = HOLD_LAST;
        end else begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= IDLE;
      holdCnt <= '0;
    end else begin
      state   <= stateNext;
      holdCnt <= holdNext;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      lastSeen <= '0;
      shown    <= '0;
      rdPtr    <= '0;
      wrPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      lastSeen <= dataIn;
      if (accept) wrPtr <= wrPtr + PW'(1);
      if (pop) begin
        shown <= fifoMem[rdPtr];
        rdPtr <= rdPtr + PW'(1);
      end
      case ({accept, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (accept) fifoMem[wrPtr] <= dataIn;
  end

  assign ledOut  = ACTIVE_LOW ? ~shown : shown;
  assign pending = count;

endmodule
